oled_ctrl_sequencer: RTL and testbench

- Sequences the OLED SPI byte transmitter (load_data/din/msg_done handshake) and drives the OLED panel control pins (VDD, VBAT, RES, D/C).
- After reset it performs the SSD1306 power-up and init command sequence autonomously, then accepts command/data bytes from the frame/pixel logic over a valid/ready handshake.
- Sits between the display-content logic and the SPI transmitter in the object-detection display path.

---
 rtl/oled_pkg.sv | 37 +++
 rtl/oled_delay_timer.sv | 42 ++++
 rtl/oled_ctrl_sequencer.sv | 170 +++++++++++++++++
 tb/tb_oled_ctrl_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED control sequencer: init command ROM,
// panel command constants and the sequencer state encoding.
package oled_pkg;

  localparam int unsigned N_INIT_PRE   = 5;
  localparam int unsigned N_INIT_TOTAL = 12;
  localparam int unsigned ROM_IDX_W    = 4;

  localparam logic [ROM_IDX_W-1:0] PRE_END   = ROM_IDX_W'(N_INIT_PRE);
  localparam logic [ROM_IDX_W-1:0] TOTAL_END = ROM_IDX_W'(N_INIT_TOTAL);

  localparam logic [7:0] DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] DISPLAY_ON  = 8'hAF;

  // Entry [0] is sent first; [0..4] before VBAT, [5..11] after.
  localparam logic [N_INIT_TOTAL-1:0][7:0] INIT_ROM = {
    DISPLAY_ON, 8'h20, 8'hDA, 8'hC8, 8'hA1, 8'h0F, 8'h81,
    8'hF1, 8'hD9, 8'h14, 8'h8D, DISPLAY_OFF
  };

  typedef enum logic [3:0] {
    ST_VDD_ON,
    ST_WAIT_VDD,
    ST_RES_LO,
    ST_RES_HI,
    ST_CMD_A,
    ST_VBAT_ON,
    ST_WAIT_VBAT,
    ST_CMD_B,
    ST_READY,
    ST_LOAD,
    ST_PRE,
    ST_HOLD,
    ST_DROP
  } seq_state_t;

endpackage

// File: rtl/oled_delay_timer.sv
// Reusable delay timer: after a one-cycle start pulse, done pulses on the
// last of units*DLY_UNIT_CYCLES cycles (the start cycle counts as the first).
// A total of 0 or 1 cycles gives done in the start cycle itself.
module oled_delay_timer
  #(parameter int unsigned DLY_UNIT_CYCLES = 100000)
  (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] units,
    output logic       done
  );

  localparam int unsigned MAX_CYCLES = 100 * DLY_UNIT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      total;
  logic [CNT_W-1:0] cnt;
  logic             active;

  assign total = 32'(units) * DLY_UNIT_CYCLES;

  // Down-counter; remaining cycles including the current one once active.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= CNT_W'(total - 32'd1);
      active <= (total > 32'd1);
    end else if (active) begin
      if (cnt == CNT_W'(1)) active <= 1'b0;
      else                  cnt    <= cnt - CNT_W'(1);
    end
  end

  // Done pulse: immediate for short delays, else when the count expires.
  always_comb begin
    done = (start && (total <= 32'd1)) || (active && (cnt == CNT_W'(1)));
  end

endmodule

// File: rtl/oled_ctrl_sequencer.sv
// OLED control sequencer: SSD1306 power-up/init, then forwards command and
// data bytes from the display logic to the SPI byte transmitter.
module oled_ctrl_sequencer
  import oled_pkg::*;
  #(
    parameter int unsigned DLY_UNIT_CYCLES = 100000,
    parameter int unsigned VDD_DLY_UNITS   = 1,
    parameter int unsigned RES_DLY_UNITS   = 1,
    parameter int unsigned VBAT_DLY_UNITS  = 100
  )
  (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic       wr_dc,
    input  logic [7:0] wr_byte,
    output logic       wr_ready,
    output logic       init_done,
    output logic       busy,
    output logic       spi_load,
    output logic [7:0] spi_din,
    input  logic       spi_done,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic       oled_vdd_n,
    output logic       oled_vbat_n
  );

  seq_state_t           state;
  seq_state_t           ret_state;
  logic [ROM_IDX_W-1:0] rom_idx;
  logic [7:0]           tx_byte;
  logic                 tx_dc;
  logic                 tmr_start;
  logic [7:0]           tmr_units;
  logic                 tmr_done;
  logic                 done_meta;
  logic                 done_sync;

  oled_delay_timer #(.DLY_UNIT_CYCLES(DLY_UNIT_CYCLES)) u_timer (
    .clock (clock),
    .reset (reset),
    .start (tmr_start),
    .units (tmr_units),
    .done  (tmr_done)
  );

  // Bring transmitter done from the slow SPI clock domain into ours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
    end else begin
      done_meta <= spi_done;
      done_sync <= done_meta;
    end
  end

  // Main sequencer. Every byte goes through LOAD/PRE/HOLD/DROP and then
  // returns to ret_state, which picks the next byte or the next phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_VDD_ON;
      ret_state   <= ST_VDD_ON;
      rom_idx     <= '0;
      tx_byte     <= '0;
      tx_dc       <= 1'b0;
      tmr_start   <= 1'b0;
      tmr_units   <= '0;
      spi_load    <= 1'b0;
      spi_din     <= '0;
      oled_dc     <= 1'b0;
      oled_res_n  <= 1'b1;
      oled_vdd_n  <= 1'b1;
      oled_vbat_n <= 1'b1;
      wr_ready    <= 1'b0;
      init_done   <= 1'b0;
      busy        <= 1'b1;
    end else begin
      tmr_start <= 1'b0;
      case (state)
        ST_VDD_ON: begin
          oled_vdd_n <= 1'b0;
          tmr_units  <= 8'(VDD_DLY_UNITS);
          tmr_start  <= 1'b1;
          state      <= ST_WAIT_VDD;
        end
        ST_WAIT_VDD: if (tmr_done) begin
          oled_res_n <= 1'b0;
          tmr_units  <= 8'(RES_DLY_UNITS);
          tmr_start  <= 1'b1;
          state      <= ST_RES_LO;
        end
        ST_RES_LO: if (tmr_done) begin
          oled_res_n <= 1'b1;
          tmr_units  <= 8'(RES_DLY_UNITS);
          tmr_start  <= 1'b1;
          state      <= ST_RES_HI;
        end
        ST_RES_HI: if (tmr_done) begin
          rom_idx <= '0;
          state   <= ST_CMD_A;
        end
        ST_CMD_A: begin
          if (rom_idx < PRE_END) begin
            tx_byte   <= INIT_ROM[rom_idx];
            tx_dc     <= 1'b0;
            rom_idx   <= rom_idx + ROM_IDX_W'(1);
            ret_state <= ST_CMD_A;
            state     <= ST_LOAD;
          end else begin
            state <= ST_VBAT_ON;
          end
        end
        ST_VBAT_ON: begin
          oled_vbat_n <= 1'b0;
          tmr_units   <= 8'(VBAT_DLY_UNITS);
          tmr_start   <= 1'b1;
          state       <= ST_WAIT_VBAT;
        end
        ST_WAIT_VBAT: if (tmr_done) state <= ST_CMD_B;
        ST_CMD_B: begin
          if (rom_idx < TOTAL_END) begin
            tx_byte   <= INIT_ROM[rom_idx];
            tx_dc     <= 1'b0;
            rom_idx   <= rom_idx + ROM_IDX_W'(1);
            ret_state <= ST_CMD_B;
            state     <= ST_LOAD;
          end else begin
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_READY;
          end
        end
        ST_READY: if (wr_valid && wr_ready) begin
          tx_byte   <= wr_byte;
          tx_dc     <= wr_dc;
          wr_ready  <= 1'b0;
          busy      <= 1'b1;
          ret_state <= ST_READY;
          state     <= ST_LOAD;
        end
        ST_LOAD: begin
          spi_din <= tx_byte;
          oled_dc <= tx_dc;
          state   <= ST_PRE;
        end
        // A stale done from a previous transfer must clear before loading.
        ST_PRE: if (!done_sync) begin
          spi_load <= 1'b1;
          state    <= ST_HOLD;
        end
        ST_HOLD: if (done_sync) begin
          spi_load <= 1'b0;
          state    <= ST_DROP;
        end
        ST_DROP: if (!done_sync) begin
          state <= ret_state;
          if (ret_state == ST_READY) begin
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= ST_VDD_ON;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_ctrl_sequencer.sv
// Directed bench for oled_ctrl_sequencer with a simple transmitter model
// that raises done 20 cycles after load and drops it once load falls.
module tb_oled_ctrl_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_dc = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       wr_ready, init_done, busy, spi_load, spi_done;
  logic [7:0] spi_din;
  logic       oled_dc, oled_res_n, oled_vdd_n, oled_vbat_n;

  logic model_done = 1'b0;
  logic stale_force = 1'b0;
  int   model_cnt = 0;

  always #5 clock = ~clock;

  assign spi_done = model_done | stale_force;

  oled_ctrl_sequencer #(
    .DLY_UNIT_CYCLES(10),
    .VDD_DLY_UNITS(1),
    .RES_DLY_UNITS(1),
    .VBAT_DLY_UNITS(100)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_dc(wr_dc), .wr_byte(wr_byte),
    .wr_ready(wr_ready), .init_done(init_done), .busy(busy),
    .spi_load(spi_load), .spi_din(spi_din), .spi_done(spi_done),
    .oled_dc(oled_dc), .oled_res_n(oled_res_n),
    .oled_vdd_n(oled_vdd_n), .oled_vbat_n(oled_vbat_n)
  );

  // Transmitter model
  always @(posedge clock) begin
    if (spi_load && !model_done) begin
      model_cnt = model_cnt + 1;
      if (model_cnt >= 20) model_done <= 1'b1;
    end else if (!spi_load) begin
      model_cnt = 0;
      if (model_done) model_done <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0] din;
    logic       dc;
    logic       rdy;
    int         cyc;
  } xfer_t;

  xfer_t log_q[$];
  xfer_t x;
  logic  prev_load = 1'b0;
  logic  prev_vbat = 1'b1;
  int    cyc = 0;
  int    vbat_idx = -1;
  int    vbat_cyc = 0;
  logic  early_ready = 1'b0;

  // Transfer monitor: logs each spi_load rise and the VBAT enable point
  always @(posedge clock) begin
    if (spi_load && !prev_load) begin
      x.din = spi_din; x.dc = oled_dc; x.rdy = wr_ready; x.cyc = cyc;
      log_q.push_back(x);
    end
    if (prev_vbat && !oled_vbat_n) begin
      vbat_idx = log_q.size();
      vbat_cyc = cyc;
    end
    prev_load <= spi_load;
    prev_vbat <= oled_vbat_n;
    cyc <= cyc + 1;
  end

  always @(negedge clock) if (wr_ready && !init_done) early_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_spi_load"}, 32'(spi_load), 0);
    chk({tag, "_spi_din"}, 32'(spi_din), 0);
    chk({tag, "_oled_dc"}, 32'(oled_dc), 0);
    chk({tag, "_res_n"}, 32'(oled_res_n), 1);
    chk({tag, "_vdd_n"}, 32'(oled_vdd_n), 1);
    chk({tag, "_vbat_n"}, 32'(oled_vbat_n), 1);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 0);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  typedef struct {
    logic       dc;
    logic [7:0] data_in;
    logic [7:0] exp_din;
    logic       exp_dc;
  } wvec_t;

  wvec_t      wv[4];
  logic [7:0] exp_init[12];
  logic [7:0] b2b_byte[3];
  logic       b2b_dc[3];
  int t, lo, base, gap;
  logic saw_load;

  initial begin
    exp_init = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
                 8'h81, 8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
    wv[0] = '{1'b1, 8'h5A, 8'h5A, 1'b1};
    wv[1] = '{1'b0, 8'hA5, 8'hA5, 1'b0};
    wv[2] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
    wv[3] = '{1'b0, 8'h00, 8'h00, 1'b0};
    b2b_byte = '{8'h01, 8'h02, 8'h03};
    b2b_dc   = '{1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    reset = 1'b1;

    // Power-up pins
    t = 0;
    while (oled_vdd_n && t < 50) begin @(negedge clock); t++; end
    chk("vdd_on", 32'(oled_vdd_n), 0);
    chk("res_high_at_vdd", 32'(oled_res_n), 1);
    t = 0;
    while (oled_res_n && t < 50) begin @(negedge clock); t++; end
    lo = 0;
    while (!oled_res_n && lo < 100) begin lo++; @(negedge clock); end
    chk("res_low_cycles", 32'(lo), 10);

    // Init sequence
    t = 0;
    while (!init_done && t < 5000) begin @(negedge clock); t++; end
    chk("init_done", 32'(init_done), 1);
    chk("init_count", 32'(log_q.size()), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("init_byte%0d", i), 32'(log_q[i].din), 32'(exp_init[i]));
        chk($sformatf("init_dc%0d", i), 32'(log_q[i].dc), 0);
      end
    end
    chk("vbat_after_f1", 32'(vbat_idx), 5);
    if (log_q.size() > 5) begin
      gap = log_q[5].cyc - vbat_cyc;
      n_checks++;
      if (gap < 1000 || gap > 1010) begin
        n_fail++;
        $display("FAIL vbat_wait: got %0d cycles, expected 1000..1010", gap);
      end
    end
    chk("ready_after_init", 32'(wr_ready), 1);
    chk("idle_after_init", 32'(busy), 0);

    // Single writes
    for (int i = 0; i < 4; i++) begin
      base = log_q.size();
      t = 0;
      while (!wr_ready && t < 300) begin @(negedge clock); t++; end
      wr_valid = 1'b1; wr_dc = wv[i].dc; wr_byte = wv[i].data_in;
      @(negedge clock);
      wr_valid = 1'b0; wr_dc = ~wv[i].dc; wr_byte = ~wv[i].data_in;
      chk($sformatf("wr%0d_ready_drop", i), 32'(wr_ready), 0);
      t = 0;
      while (log_q.size() == base && t < 300) begin @(negedge clock); t++; end
      chk($sformatf("wr%0d_count", i), 32'(log_q.size() - base), 1);
      if (log_q.size() > base) begin
        chk($sformatf("wr%0d_din", i), 32'(log_q[base].din), 32'(wv[i].exp_din));
        chk($sformatf("wr%0d_dc", i), 32'(log_q[base].dc), 32'(wv[i].exp_dc));
        chk($sformatf("wr%0d_rdy_in_send", i), 32'(log_q[base].rdy), 0);
      end
      t = 0;
      while (busy && t < 300) begin @(negedge clock); t++; end
      chk($sformatf("wr%0d_ready_after", i), 32'(wr_ready), 1);
      chk($sformatf("wr%0d_single", i), 32'(log_q.size() - base), 1);
    end

    // Back-to-back with wr_valid held
    base = log_q.size();
    wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_byte = b2b_byte[k]; wr_dc = b2b_dc[k];
      t = 0;
      while (!wr_ready && t < 300) begin @(negedge clock); t++; end
      @(posedge clock);
      @(negedge clock);
    end
    wr_valid = 1'b0;
    t = 0;
    while ((log_q.size() - base < 3 || busy) && t < 600) begin @(negedge clock); t++; end
    repeat (50) @(negedge clock);
    chk("b2b_count", 32'(log_q.size() - base), 3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < log_q.size()) begin
        chk($sformatf("b2b_din%0d", k), 32'(log_q[base + k].din), 32'(b2b_byte[k]));
        chk($sformatf("b2b_dc%0d", k), 32'(log_q[base + k].dc), 32'(b2b_dc[k]));
      end
    end

    // Stale done at start of a transfer
    base = log_q.size();
    stale_force = 1'b1;
    t = 0;
    while (!wr_ready && t < 300) begin @(negedge clock); t++; end
    wr_valid = 1'b1; wr_dc = 1'b0; wr_byte = 8'hC3;
    @(negedge clock);
    wr_valid = 1'b0;
    saw_load = 1'b0;
    repeat (60) begin @(negedge clock); if (spi_load) saw_load = 1'b1; end
    chk("stale_no_load", 32'(saw_load), 0);
    chk("stale_busy", 32'(busy), 1);
    stale_force = 1'b0;
    t = 0;
    while (log_q.size() == base && t < 300) begin @(negedge clock); t++; end
    chk("stale_count", 32'(log_q.size() - base), 1);
    if (log_q.size() > base) chk("stale_din", 32'(log_q[base].din), 32'hC3);
    t = 0;
    while (busy && t < 300) begin @(negedge clock); t++; end
    chk("stale_idle", 32'(busy), 0);

    // Re-init with early request held, reset during CMD_B send
    reset = 1'b0;
    @(negedge clock);
    early_ready = 1'b0;
    reset = 1'b1;
    wr_valid = 1'b1; wr_dc = 1'b1; wr_byte = 8'hEE;
    base = log_q.size();
    t = 0;
    while (!((log_q.size() - base >= 7) && spi_load) && t < 5000) begin @(negedge clock); t++; end
    chk("mid_send_load", 32'(spi_load), 1);
    if (log_q.size() > base + 6) chk("mid_send_byte", 32'(log_q[base + 6].din), 32'h0F);
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clock);
    reset = 1'b1;
    base = log_q.size();
    t = 0;
    while (!init_done && t < 5000) begin @(negedge clock); t++; end
    chk("reinit_done", 32'(init_done), 1);
    chk("reinit_count", 32'(log_q.size() - base), 12);
    for (int i = 0; i < 12; i++) begin
      if (base + i < log_q.size())
        chk($sformatf("reinit_byte%0d", i), 32'(log_q[base + i].din), 32'(exp_init[i]));
    end
    chk("early_ready", 32'(early_ready), 0);
    t = 0;
    while (log_q.size() - base < 13 && t < 300) begin @(negedge clock); t++; end
    wr_valid = 1'b0;
    chk("late_accept_count", 32'(log_q.size() - base), 13);
    if (log_q.size() > base + 12) begin
      chk("late_accept_din", 32'(log_q[base + 12].din), 32'hEE);
      chk("late_accept_dc", 32'(log_q[base + 12].dc), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
